record_reader: RTL and testbench
================================

RECORD_READER -- requirements
Module: record_reader

Interface
REQ-001 Parameter DEPTH, default 8: record FIFO depth in records; power of two, minimum 2.
REQ-002 Parameter LOST_W, default 16: width of the lost-record counter.
REQ-003 Port clk, input, 1: the single clock; all logic rises on clk.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port data_rdy, input, 1: one-cycle strobe marking data as a valid timetag record.
REQ-006 Port data, input, 47: timetag record; opaque payload, sampled only when data_rdy=1.
REQ-007 Port byte_out, output, 8: current serialized byte to the host.
REQ-008 Port byte_valid, output, 1: byte_out is valid.
REQ-009 Port byte_ack, input, 1: host accepts byte_out this cycle; ignored when byte_valid=0.
REQ-010 Port fifo_full, output, 1: FIFO holds DEPTH records.
REQ-011 Port lost_count, output, LOST_W: saturating count of dropped records since reset.

Function
REQ-012 Accepted-record word: 48 bits, {lost_flag, data[46:0]}.
REQ-013 lost_flag=1 marks that one or more records were dropped immediately before this record.
REQ-014 Write rule: data_rdy=1 with FIFO not full writes the word at that clk edge.
REQ-015 Drop rule: data_rdy=1 with FIFO full drops the record, even if a pop occurs the same cycle.
REQ-016 On a drop: lost_count increments, saturating at 2^LOST_W-1; lost_pending sets.
REQ-017 lost_pending is copied into bit 47 of the next accepted word, then clears on that write.
REQ-018 fifo_full is registered and reflects occupancy after each edge.
REQ-019 Serializer FSM states: IDLE and SEND.
REQ-020 IDLE: if the FIFO is non-empty, pop the head into a 48-bit holding register, set byte index 0, go to SEND; otherwise stay in IDLE.
REQ-021 SEND: byte_valid=1 and byte_out = hold[8*idx+7 : 8*idx], so bytes leave LSB first, 6 per record.
REQ-022 SEND, byte_ack=1 and idx<5: idx increments.
REQ-023 SEND, byte_ack=1 and idx=5: pop the next record and reset idx to 0 if the FIFO is non-empty (back-to-back, no idle cycle); else go to IDLE.
REQ-024 SEND, byte_ack=0: byte_out and byte_valid hold stable.
REQ-025 Latency: data_rdy sampled at edge N with FIFO empty and FSM idle gives byte_valid=1 from edge N+2.
REQ-026 Throughput: sustained one byte per cycle with byte_ack held at 1.
REQ-027 No record is ever partially emitted, reordered or duplicated.

Reset
REQ-028 Reset clears the FIFO pointers, the FSM (to IDLE), idx, lost_pending and lost_count.
REQ-029 While reset is asserted: byte_valid=0, byte_out=0, fifo_full=0, lost_count=0.
REQ-030 Reset mid-record abandons the record in flight; output resumes with the next record written after reset.

Structure
REQ-031 Shared package constants: RECORD_W=47, WORD_W=48, BYTES_PER_RECORD=6, and the FSM state encoding.
REQ-032 The synchronous FIFO is a separate sub-module, record_fifo (params WIDTH, DEPTH; ports wr_en, din, rd_en, dout, empty, full).
REQ-033 record_reader contains the drop/lost logic and the serializer FSM.

Verification
REQ-034 Single record: data=47'h0123_4567_89AB, host always acks -> bytes AB,89,67,45,23,01 on 6 consecutive cycles, starting 2 cycles after the strobe.
REQ-035 Backpressure: byte_ack held 0 for 10 cycles on byte 2 -> byte_out holds 67 with byte_valid=1 throughout; no byte lost.
REQ-036 Overflow: DEPTH=8, byte_ack=0, 10 strobes -> fifo_full=1, lost_count=2; the 11th record, once the host drains, has top byte bit 7=1; all other records have it 0.
REQ-037 Back-to-back: 3 records queued, ack always 1 -> 18 consecutive valid bytes with no bubble; byte_valid falls after the last.
REQ-038 Saturation: LOST_W=4, 20 drops -> lost_count=15 and holds there.
REQ-039 Mid-record reset: reset asserted after byte 3 is acked -> byte_valid=0 and lost_count=0; a new record then emits in full from byte 0.

Source files
------------

// File: rtl/record_reader_pkg.sv
// record_reader_pkg
//   Constants shared by the record reader and its FIFO: record and word
//   widths, bytes per serialized word, serializer state encoding and a helper
//   that picks one byte out of a word.
package record_reader_pkg;

    localparam int RECORD_W         = 47;
    localparam int WORD_W           = 48;
    localparam int BYTES_PER_RECORD = 6;
    localparam int IDX_W            = 3;

    // Serializer FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Word stored in the FIFO. lost marks a gap just before this record.
    typedef struct packed {
        logic                lost;
        logic [RECORD_W-1:0] rec;
    } word_t;

    // Byte idx of a word, byte 0 being the least significant.
    function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                             input logic [IDX_W-1:0]  idx);
        return w[8*int'(idx) +: 8];
    endfunction

endpackage

// File: rtl/record_fifo.sv
// record_fifo
//   Synchronous show-ahead FIFO: dout always presents the head entry, and
//   rd_en pops it at the clock edge. empty and full are registered and
//   reflect the occupancy after each edge.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   wr_en, din    push din (ignored when full)
//   rd_en, dout   pop the head (ignored when empty); dout = current head
//   empty, full   occupancy flags
module record_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_next;
    logic             do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_wr && !do_rd)
            count_next = count + 1'b1;
        else if (!do_wr && do_rd)
            count_next = count - 1'b1;
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/record_reader.sv
// record_reader
//   Accepts 47-bit timetag records, tags each accepted record with a lost
//   flag when records were dropped just before it, queues the 48-bit words
//   in a FIFO and serializes them to the host LSB byte first, 6 bytes per
//   word, under a valid/ack handshake.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   data_rdy, data        record strobe and payload
//   byte_out, byte_valid  serialized byte to the host and its valid flag
//   byte_ack              host takes byte_out this cycle
//   fifo_full             FIFO holds DEPTH words
//   lost_count            saturating count of dropped records
module record_reader
    import record_reader_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int LOST_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                data_rdy,
    input  logic [RECORD_W-1:0] data,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ack,
    output logic                fifo_full,
    output logic [LOST_W-1:0]   lost_count
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_RECORD - 1);

    logic              wr_en, drop, rd_en, empty;
    logic              lost_pending;
    word_t             din_word;
    logic [WORD_W-1:0] head;
    logic [WORD_W-1:0] hold;
    logic [IDX_W-1:0]  idx;
    logic [0:0]        state;

    // ---------------- input side: accept or drop ----------------
    // fifo_full is the registered flag from before this edge, so a record
    // arriving while full is dropped even if a pop frees a slot right now.
    assign wr_en = data_rdy && !fifo_full;
    assign drop  = data_rdy &&  fifo_full;

    assign din_word.lost = lost_pending;
    assign din_word.rec  = data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_pending <= 1'b0;
            lost_count   <= '0;
        end else begin
            if (drop)
                lost_pending <= 1'b1;
            else if (wr_en)
                lost_pending <= 1'b0;
            if (drop && lost_count != '1)
                lost_count <= lost_count + 1'b1;
        end
    end

    record_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (wr_en),
        .din   (din_word),
        .rd_en (rd_en),
        .dout  (head),
        .empty (empty),
        .full  (fifo_full)
    );

    // ---------------- serializer ----------------
    // A pop happens from IDLE, or on the ack of the last byte so the next
    // word follows without a bubble.
    always_comb begin
        rd_en = 1'b0;
        if (state == ST_IDLE)
            rd_en = !empty;
        else if (byte_ack && idx == LAST_IDX)
            rd_en = !empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_en) begin
                        hold  <= head;
                        idx   <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (byte_ack) begin
                        if (idx != LAST_IDX) begin
                            idx <= idx + 1'b1;
                        end else if (rd_en) begin
                            hold <= head;
                            idx  <= '0;
                        end else begin
                            idx   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign byte_valid = (state == ST_SEND);
    assign byte_out   = byte_valid ? word_byte(hold, idx) : 8'h00;

endmodule

// File: tb/tb_record_reader.sv
module tb_record_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_rdy;
    logic [46:0] data;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ack;
    logic        fifo_full;
    logic [15:0] lost_count;

    // second instance, small FIFO and narrow counter for saturation
    logic        sat_rdy;
    logic [46:0] sat_data;
    logic [7:0]  sat_byte;
    logic        sat_valid;
    logic        sat_ack;
    logic        sat_full;
    logic [3:0]  sat_lost;

    always #5 clk = ~clk;

    record_reader #(.DEPTH(8), .LOST_W(16)) dut (
        .clk(clk), .reset(reset), .data_rdy(data_rdy), .data(data),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ack(byte_ack),
        .fifo_full(fifo_full), .lost_count(lost_count)
    );

    record_reader #(.DEPTH(2), .LOST_W(4)) u_sat (
        .clk(clk), .reset(reset), .data_rdy(sat_rdy), .data(sat_data),
        .byte_out(sat_byte), .byte_valid(sat_valid), .byte_ack(sat_ack),
        .fifo_full(sat_full), .lost_count(sat_lost)
    );

    typedef struct {
        logic [46:0]     data;
        logic [5:0][7:0] bytes;   // bytes[0] leaves first
    } vec_t;

    vec_t vecs[5];
    int   n_pass  = 0;
    int   n_total = 0;

    logic       logging = 1'b0;
    logic [8:0] log_q[$];
    logic [7:0] got_q[$];

    // per-cycle record of {byte_valid, byte_out}, taken on the falling edge
    always @(negedge clk)
        if (logging) log_q.push_back({byte_valid, byte_out});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic collect_valid();
        got_q.delete();
        foreach (log_q[i])
            if (log_q[i][8]) got_q.push_back(log_q[i][7:0]);
    endtask

    // One record into an idle reader with the host always acking.
    // log[0] is the strobe cycle, log[1] the cycle after the write edge,
    // bytes occupy log[2..7], log[8] must be idle again.
    task automatic run_single(input int v, input string tag);
        log_q.delete();
        logging  = 1'b1;
        byte_ack = 1'b1;
        data_rdy = 1'b1;
        data     = vecs[v].data;
        tick();
        data_rdy = 1'b0;
        tick(8);
        logging = 1'b0;
        chk($sformatf("%s_latency_idle", tag), 64'(log_q[1]), 64'(9'h000));
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(log_q[2+i]), 64'({1'b1, vecs[v].bytes[i]}));
        chk($sformatf("%s_end_idle", tag), 64'(log_q[8]), 64'(9'h000));
    endtask

    initial begin
        vecs[0] = '{47'h0123_4567_89AB, {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB}};
        vecs[1] = '{47'h7FFF_FFFF_FFFF, {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[2] = '{47'h0,              {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{47'h4000_0000_0001, {8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}};
        vecs[4] = '{47'h1234_5678_9ABC, {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC}};

        reset    = 1'b1;
        data_rdy = 1'b0;
        data     = '0;
        byte_ack = 1'b0;
        sat_rdy  = 1'b0;
        sat_data = '0;
        sat_ack  = 1'b0;

        // ---- reset state ----
        tick(2);
        chk("rst_valid", 64'(byte_valid), 64'(0));
        chk("rst_byte",  64'(byte_out),   64'(0));
        chk("rst_full",  64'(fifo_full),  64'(0));
        chk("rst_lost",  64'(lost_count), 64'(0));
        reset = 1'b0;
        tick();

        // ---- single records, table driven ----
        for (int v = 0; v < 5; v++)
            run_single(v, $sformatf("vec%0d", v));

        // ---- backpressure on byte 2 for 10 cycles ----
        log_q.delete();
        logging  = 1'b1;
        byte_ack = 1'b1;
        data_rdy = 1'b1;
        data     = vecs[0].data;
        tick();
        data_rdy = 1'b0;
        tick(3);
        byte_ack = 1'b0;
        tick(10);
        byte_ack = 1'b1;
        tick(6);
        logging = 1'b0;
        chk("bp_b0", 64'(log_q[2]), 64'({1'b1, 8'hAB}));
        chk("bp_b1", 64'(log_q[3]), 64'({1'b1, 8'h89}));
        for (int i = 4; i <= 14; i++)
            chk($sformatf("bp_hold%0d", i - 4), 64'(log_q[i]), 64'({1'b1, 8'h67}));
        chk("bp_b3",  64'(log_q[15]), 64'({1'b1, 8'h45}));
        chk("bp_b4",  64'(log_q[16]), 64'({1'b1, 8'h23}));
        chk("bp_b5",  64'(log_q[17]), 64'({1'b1, 8'h01}));
        chk("bp_end", 64'(log_q[18]), 64'(9'h000));

        // ---- three records back to back ----
        log_q.delete();
        logging  = 1'b1;
        data_rdy = 1'b1;
        data     = vecs[0].data;
        tick();
        data     = vecs[1].data;
        tick();
        data     = vecs[2].data;
        tick();
        data_rdy = 1'b0;
        tick(18);
        logging = 1'b0;
        chk("b2b_pre", 64'(log_q[1]), 64'(9'h000));
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 6; i++)
                chk($sformatf("b2b_r%0d_b%0d", r, i), 64'(log_q[2 + 6*r + i]),
                    64'({1'b1, vecs[r].bytes[i]}));
        chk("b2b_end", 64'(log_q[20]), 64'(9'h000));

        // ---- overflow ----
        // Park one record in the serializer with the host stalled so the
        // FIFO itself starts empty; then 10 strobes fill 8 slots, drop 2.
        byte_ack = 1'b0;
        data_rdy = 1'b1;
        data     = 47'hF0;
        tick();
        data_rdy = 1'b0;
        tick(2);
        for (int i = 1; i <= 10; i++) begin
            data_rdy = 1'b1;
            data     = 47'(i);
            tick();
        end
        data_rdy = 1'b0;
        chk("ovf_full",    64'(fifo_full),  64'(1));
        chk("ovf_lost",    64'(lost_count), 64'(2));
        chk("ovf_hold_b0", 64'({byte_valid, byte_out}), 64'({1'b1, 8'hF0}));
        log_q.delete();
        logging  = 1'b1;
        byte_ack = 1'b1;
        tick(60);
        logging = 1'b0;
        collect_valid();
        chk("ovf_drain_count", 64'(got_q.size()), 64'(54));
        for (int r = 0; r < 9; r++)
            for (int i = 0; i < 6; i++)
                chk($sformatf("ovf_r%0d_b%0d", r, i), 64'(got_q[6*r + i]),
                    64'((i != 0) ? 8'h00 : (r == 0) ? 8'hF0 : 8'(r)));
        chk("ovf_drained_full", 64'(fifo_full),  64'(0));
        chk("ovf_lost_kept",    64'(lost_count), 64'(2));
        // 11th record carries the lost flag, the 12th does not
        log_q.delete();
        logging  = 1'b1;
        data_rdy = 1'b1;
        data     = 47'h0B;
        tick();
        data     = 47'h0C;
        tick();
        data_rdy = 1'b0;
        tick(14);
        logging = 1'b0;
        collect_valid();
        chk("flag_count",   64'(got_q.size()), 64'(12));
        chk("flag_r11_b0",  64'(got_q[0]),  64'(8'h0B));
        chk("flag_r11_top", 64'(got_q[5]),  64'(8'h80));
        chk("flag_r12_b0",  64'(got_q[6]),  64'(8'h0C));
        chk("flag_r12_top", 64'(got_q[11]), 64'(8'h00));

        // ---- reset in the middle of a record ----
        byte_ack = 1'b1;
        data_rdy = 1'b1;
        data     = vecs[4].data;
        tick();
        data_rdy = 1'b0;
        tick(5);   // bytes 0..3 acked, byte 4 now showing
        chk("mid_pre_byte", 64'({byte_valid, byte_out}), 64'({1'b1, 8'h34}));
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(byte_valid), 64'(0));
        chk("mid_rst_byte",  64'(byte_out),   64'(0));
        chk("mid_rst_lost",  64'(lost_count), 64'(0));
        chk("mid_rst_full",  64'(fifo_full),  64'(0));
        tick(2);
        reset = 1'b0;
        tick();
        chk("mid_post_idle", 64'(byte_valid), 64'(0));
        run_single(0, "mid_new");

        // ---- lost counter saturation (DEPTH=2, LOST_W=4) ----
        // r1 goes to the serializer, r2/r3 fill the FIFO, r4..r23 drop.
        sat_ack = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            sat_rdy  = 1'b1;
            sat_data = 47'(i);
            tick();
            if (i == 10) chk("sat_lost_7", 64'(sat_lost), 64'(7));
            if (i == 18) chk("sat_lost_15", 64'(sat_lost), 64'(15));
        end
        sat_rdy = 1'b0;
        tick(3);
        chk("sat_lost_hold", 64'(sat_lost),  64'(15));
        chk("sat_full",      64'(sat_full),  64'(1));
        chk("sat_first",     64'({sat_valid, sat_byte}), 64'({1'b1, 8'h01}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
